// File: rtl/aes_pkg.sv
// Shared AES definitions: inverse-substitution FSM state type, state size and
// the InvShiftRows byte-index mapping used when capturing a state.
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } invSubFsmT;

  // Output byte j (column-major, j = 4*col + row) takes input byte INV_SHIFT_ROWS_MAP[j]
  localparam logic [3:0] INV_SHIFT_ROWS_MAP [AES_STATE_BYTES] = '{
    4'd0, 4'd13, 4'd10, 4'd7,
    4'd4, 4'd1,  4'd14, 4'd11,
    4'd8, 4'd5,  4'd2,  4'd15,
    4'd12, 4'd9, 4'd6,  4'd3
  };

  function automatic logic [127:0] invShiftRows(input logic [127:0] st);
    logic [127:0] res;
    res = 128'd0;
    for (int j = 0; j < AES_STATE_BYTES; j++) begin
      res[127 - 8*j -: 8] = st[127 - 8*int'(INV_SHIFT_ROWS_MAP[j]) -: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box: purely combinational 256-entry byte lookup.
module inv_sbox (
  input  logic [7:0] dataByte,
  output logic [7:0] invByte
);

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign invByte = INV_SBOX[dataByte];

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes, LANES bytes per clock, valid/ready on both sides.
// Define INV_SUB_BYTES_SHIFTROWS_EN to apply InvShiftRows to the captured state.
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_CHUNKS = AES_STATE_BYTES / LANES;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  invSubFsmT        fsmR;
  logic [CNT_W-1:0] cntR;
  logic [127:0]     workR;
  logic [127:0]     nextWork;
  logic [127:0]     captureState;
  logic [127:0]     outStateR;
  logic             inReadyR;
  logic             outValidR;
  logic             busyR;
  logic [7:0]       sboxIn  [LANES];
  logic [7:0]       sboxOut [LANES];

  for (genvar l = 0; l < LANES; l++) begin : gLane
    inv_sbox uInvSbox (
      .dataByte (sboxIn[l]),
      .invByte  (sboxOut[l])
    );
  end

`ifdef INV_SUB_BYTES_SHIFTROWS_EN
  assign captureState = invShiftRows(in_state);
`else
  assign captureState = in_state;
`endif

  // Select the current chunk of the working state for the S-box lanes
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sboxIn[l] = workR[127 - 8*(int'(cntR)*LANES + l) -: 8];
    end
  end

  // Working state with the current chunk replaced by its inverse-S values
  always_comb begin
    nextWork = workR;
    for (int l = 0; l < LANES; l++) begin
      nextWork[127 - 8*(int'(cntR)*LANES + l) -: 8] = sboxOut[l];
    end
  end

  // Control FSM, working register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsmR      <= IDLE;
      cntR      <= '0;
      workR     <= 128'd0;
      outStateR <= 128'd0;
      inReadyR  <= 1'b1;
      outValidR <= 1'b0;
      busyR     <= 1'b0;
    end else begin
      case (fsmR)
        IDLE: begin
          if (in_valid) begin
            workR    <= captureState;
            cntR     <= '0;
            fsmR     <= RUN;
            inReadyR <= 1'b0;
            busyR    <= 1'b1;
          end
        end
        RUN: begin
          workR <= nextWork;
          if (cntR == LAST_CNT) begin
            // Result is published on the same edge that finishes the last chunk
            cntR      <= '0;
            fsmR      <= DONE;
            outValidR <= 1'b1;
            outStateR <= nextWork;
          end else begin
            cntR <= cntR + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsmR      <= IDLE;
            outValidR <= 1'b0;
            outStateR <= 128'd0;
            inReadyR  <= 1'b1;
            busyR     <= 1'b0;
          end
        end
        default: begin
          fsmR      <= IDLE;
          cntR      <= '0;
          workR     <= 128'd0;
          outStateR <= 128'd0;
          inReadyR  <= 1'b1;
          outValidR <= 1'b0;
          busyR     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReadyR;
  assign out_valid = outValidR;
  assign out_state = outStateR;
  assign busy      = busyR;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes: inputs are built with the forward S-box
// (and ShiftRows when INV_SUB_BYTES_SHIFTROWS_EN is set) so results are plaintext.
module tb_inv_sub_bytes;

  localparam int LANES      = 4;
  localparam int NUM_CHUNKS = 16 / LANES;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int assertCount = 0;
  int failCount   = 0;

  inv_sub_bytes #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [127:0] act, input logic [127:0] want);
    assertCount++;
    if (act !== want) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", tag, act, want);
    end
  endtask

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = SBOX[s[127 - 8*k -: 8]];
    return r;
  endfunction

`ifdef INV_SUB_BYTES_SHIFTROWS_EN
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
    return r;
  endfunction
`endif

  function automatic logic [127:0] makeInput(input logic [127:0] plain);
`ifdef INV_SUB_BYTES_SHIFTROWS_EN
    return shiftRows(subBytes(plain));
`else
    return subBytes(plain);
`endif
  endfunction

  // One transaction with out_ready held high throughout; returns result and latency
  task automatic runOne(input logic [127:0] din, output logic [127:0] dout, output int lat);
    int guard;
    guard = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = din;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = ~din;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    dout = out_state;
    @(posedge clk); #1;
  endtask

  logic [127:0] got;
  logic [127:0] plain;
  logic [127:0] din;
  logic [127:0] streamPlain [8];
  int           lat;
  int           acceptCyc [8];
  int           guard;
  int           idx;
  int           nGot;
  logic         acceptNow;
  logic         sawValid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_state = 128'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset in_ready", 128'(in_ready), 128'd1);
    checkVal("reset out_valid", 128'(out_valid), 128'd0);
    checkVal("reset out_state", out_state, 128'd0);
    checkVal("reset busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 S-box row 0 vector
`ifdef INV_SUB_BYTES_SHIFTROWS_EN
    din = makeInput(128'h000102030405060708090a0b0c0d0e0f);
`else
    din = 128'h637c777bf26b6fc53001672bfed7ab76;
`endif
    runOne(din, got, lat);
    checkVal("fips vector", got, 128'h000102030405060708090a0b0c0d0e0f);
    checkVal("latency", 128'(lat), 128'(NUM_CHUNKS));

    runOne(128'h0, got, lat);
    checkVal("all 00", got, {16{8'h52}});
    runOne({16{8'h16}}, got, lat);
    checkVal("all 16", got, {16{8'hff}});
    runOne({16{8'hed}}, got, lat);
    checkVal("all ed", got, {16{8'h53}});

    // Exhaustive byte coverage: InvS(S(x)) = x for every x
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 16; k++) plain[127 - 8*k -: 8] = 8'(16*t + k);
      runOne(makeInput(plain), got, lat);
      checkVal($sformatf("exhaustive %0d", t), got, plain);
    end

    // Back-pressure in DONE while new data is offered
    plain = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b0; in_valid = 1'b1; in_state = makeInput(plain);
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_state = makeInput(128'hfedcba98765432100123456789abcdef);
      @(posedge clk); #1;
      checkVal("hold out_state", out_state, plain);
      checkVal("hold in_ready", 128'(in_ready), 128'd0);
      checkVal("hold out_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkVal("release out_valid", 128'(out_valid), 128'd0);
    checkVal("release in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("no capture out_valid", 128'(out_valid), 128'd0);
    checkVal("no capture busy", 128'(busy), 128'd0);

    // Reset during the second RUN cycle aborts the operation
    out_ready = 1'b1; in_valid = 1'b1; in_state = makeInput(plain);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkVal("run busy", 128'(busy), 128'd1);
    checkVal("run in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkVal("abort in_ready", 128'(in_ready), 128'd1);
    checkVal("abort out_valid", 128'(out_valid), 128'd0);
    checkVal("abort out_state", out_state, 128'd0);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sawValid |= out_valid;
    end
    checkVal("abort no result", 128'(sawValid), 128'd0);

    // Back-to-back stream with in_valid and out_ready held high
    for (int i = 0; i < 8; i++) streamPlain[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_valid = 1'b1; in_state = makeInput(streamPlain[0]);
    idx = 0; nGot = 0; guard = 0;
    while (nGot < 8 && guard < 500) begin
      acceptNow = in_valid && in_ready;
      if (out_valid) begin
        checkVal($sformatf("stream %0d", nGot), out_state, streamPlain[nGot]);
        nGot++;
      end
      @(posedge clk); #1; guard++;
      if (acceptNow && idx < 8) begin
        acceptCyc[idx] = guard;
        idx++;
        if (idx < 8) in_state = makeInput(streamPlain[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkVal("stream count", 128'(nGot), 128'd8);
    for (int i = 1; i < 8; i++)
      checkVal($sformatf("stream period %0d", i), 128'(acceptCyc[i] - acceptCyc[i-1]), 128'(NUM_CHUNKS + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
